// File: rtl/vend_dispenser.sv
// Vending actuator stage. It queues vend events from the vending FSM, runs the
// soda motor with a done/timeout handshake, then pulses the nickel hopper once
// for each 5c of change. Fault reporting is sticky.
//
// Optional feature macro: VEND_DISP_STATS_EN adds the o_vend_cnt and
// o_change_cnt statistics outputs.
//
// Ports (vend_dispenser):
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_soda, i_change[2:0] one-cycle vend strobe with its change code
//   i_motor_done          soda-drop sensor level
//   i_fault_clr           one-cycle fault clear pulse
//   o_motor               soda motor drive
//   o_nickle_eject        hopper eject pulse, one per nickel
//   o_busy, o_full        activity and queue-full status
//   o_fault               sticky fault flag
//   o_fault_code[1:0]     01 motor timeout, 10 bad change code, 11 overflow
//   o_vend_cnt, o_change_cnt  saturating statistics (VEND_DISP_STATS_EN only)

// Generic circular FIFO with count-based full/empty status.
// Latency: a push is visible at head_dat/count one cycle after its edge.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Soda/change dispenser. It queues vend events, drives the motor, then ejects nickels.
// Latency: o_motor rises on the 2nd edge after the capture edge. All outputs are registered.
// Backpressure: none toward the FSM. A strobe that arrives while the queue is full and nothing pops is dropped and flagged.
module vend_dispenser #(
    parameter int FIFO_DEPTH  = 4,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_soda,
    input  logic [2:0]  i_change,
    input  logic        i_motor_done,
    input  logic        i_fault_clr,
    output logic        o_motor,
    output logic        o_nickle_eject,
    output logic        o_busy,
    output logic        o_full,
    output logic        o_fault,
    output logic [1:0]  o_fault_code
`ifdef VEND_DISP_STATS_EN
    ,
    output logic [15:0] o_vend_cnt,
    output logic [15:0] o_change_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    typedef struct packed {
        logic [2:0] nickels;
    } vend_evt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_EJ_ON,
        S_EJ_OFF,
        S_FAULT
    } state_t;

    state_t     state;
    vend_evt_t  evt_in;
    vend_evt_t  evt_head;
    logic [2:0] nick_q;
    logic [TW-1:0] tmo_cnt;
    logic [PW-1:0] pls_cnt;
    logic       head_vld_q;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] cnt_nxt;

    logic bad_code;
    logic fifo_full;
    logic fifo_empty;
    logic tmo_last;
    logic pls_last;
    logic done_hit;
    logic tmo_hit;
    logic fin_pop;
    logic drop_pop;
    logic pop;
    logic push;
    logic ovf;
    logic       new_fault;
    logic [1:0] new_code;

    // Change decode. Any multi-bit code still vends the soda but pays nothing.
    always_comb begin
        evt_in.nickels = 3'd0;
        bad_code       = 1'b0;
        case (i_change)
            3'b000:  evt_in.nickels = 3'd0;
            3'b001:  evt_in.nickels = 3'd1;
            3'b010:  evt_in.nickels = 3'd2;
            3'b100:  evt_in.nickels = 3'd4;
            default: bad_code = i_soda;
        endcase
    end

    sync_fifo #(
        .WIDTH ($bits(vend_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .push_vld (push),
        .push_dat (evt_in),
        .pop_vld  (pop),
        .head_dat (evt_head),
        .count    (fifo_cnt)
    );

    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign tmo_last   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign pls_last   = (pls_cnt == PW'(PULSE_CYC - 1));

    // The motor-done check takes precedence over the timeout in the same cycle.
    assign done_hit = (state == S_VEND) && i_motor_done;
    assign tmo_hit  = (state == S_VEND) && !i_motor_done && tmo_last;

    // A completed vend pops. A fault clear also pops, which drops the stuck entry.
    assign fin_pop  = (done_hit && (nick_q == 3'd0)) ||
                      ((state == S_EJ_OFF) && pls_last && (nick_q == 3'd1));
    assign drop_pop = (state == S_FAULT) && i_fault_clr;
    assign pop      = fin_pop || drop_pop;

    // When the queue is full, a pop in the same cycle frees the slot for the new push.
    assign push    = i_soda && (!fifo_full || pop);
    assign ovf     = i_soda && fifo_full && !pop;
    assign cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);

    // Fault code priority: timeout, then overflow, then bad code.
    always_comb begin
        new_fault = tmo_hit || ovf || bad_code;
        new_code  = 2'b10;
        if (tmo_hit) begin
            new_code = 2'b01;
        end else if (ovf) begin
            new_code = 2'b11;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            nick_q         <= 3'd0;
            tmo_cnt        <= '0;
            pls_cnt        <= '0;
            head_vld_q     <= 1'b0;
            o_motor        <= 1'b0;
            o_nickle_eject <= 1'b0;
            o_busy         <= 1'b0;
            o_full         <= 1'b0;
            o_fault        <= 1'b0;
            o_fault_code   <= 2'b00;
        end else begin
            // Registered queue-valid view. This view gives the two-edge start
            // latency. It is forced low on a pop, so IDLE never acts on an entry
            // that has just been removed.
            head_vld_q <= !fifo_empty && !pop;

            // Every non-IDLE state goes back to IDLE only through a pop.
            o_busy <= (cnt_nxt != '0) || ((state != S_IDLE) && !pop);
            o_full <= (cnt_nxt == CW'(FIFO_DEPTH));

            // If a new fault and a clear arrive in the same cycle, the new fault wins.
            if (new_fault) begin
                o_fault      <= 1'b1;
                o_fault_code <= new_code;
            end else if (i_fault_clr) begin
                o_fault      <= 1'b0;
                o_fault_code <= 2'b00;
            end

            case (state)
                S_IDLE: begin
                    if (head_vld_q) begin
                        state   <= S_VEND;
                        nick_q  <= evt_head.nickels;
                        tmo_cnt <= '0;
                        o_motor <= 1'b1;
                    end
                end
                S_VEND: begin
                    if (i_motor_done) begin
                        o_motor <= 1'b0;
                        if (nick_q == 3'd0) begin
                            state <= S_IDLE;
                        end else begin
                            state          <= S_EJ_ON;
                            pls_cnt        <= '0;
                            o_nickle_eject <= 1'b1;
                        end
                    end else if (tmo_last) begin
                        state   <= S_FAULT;
                        o_motor <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_EJ_ON: begin
                    if (pls_last) begin
                        state          <= S_EJ_OFF;
                        pls_cnt        <= '0;
                        o_nickle_eject <= 1'b0;
                    end else begin
                        pls_cnt <= pls_cnt + PW'(1);
                    end
                end
                S_EJ_OFF: begin
                    if (pls_last) begin
                        pls_cnt <= '0;
                        nick_q  <= nick_q - 3'd1;
                        if (nick_q == 3'd1) begin
                            state <= S_IDLE;
                        end else begin
                            state          <= S_EJ_ON;
                            o_nickle_eject <= 1'b1;
                        end
                    end else begin
                        pls_cnt <= pls_cnt + PW'(1);
                    end
                end
                S_FAULT: begin
                    o_motor        <= 1'b0;
                    o_nickle_eject <= 1'b0;
                    if (i_fault_clr) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    o_motor        <= 1'b0;
                    o_nickle_eject <= 1'b0;
                end
            endcase
        end
    end

`ifdef VEND_DISP_STATS_EN
    // An entry dropped by a fault clear is not counted as a completed vend.
    logic pulse_start;
    assign pulse_start = (done_hit && (nick_q != 3'd0)) ||
                         ((state == S_EJ_OFF) && pls_last && (nick_q != 3'd1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vend_cnt   <= 16'd0;
            o_change_cnt <= 16'd0;
        end else begin
            if (fin_pop && (o_vend_cnt != 16'hFFFF)) begin
                o_vend_cnt <= o_vend_cnt + 16'd1;
            end
            if (pulse_start) begin
                o_change_cnt <= (o_change_cnt > 16'hFFFA) ? 16'hFFFF : o_change_cnt + 16'd5;
            end
        end
    end
`endif
endmodule
